// File: rtl/filter_boxcar_mc.sv
// N-channel time-multiplexed moving-average (boxcar) filter with raw-sample passthrough.
// Optional define FILTER_SIGNMAG_EN selects sign-magnitude dout instead of two's complement.
module filter_boxcar_mc #(
  parameter int unsigned CH        = 4,
  parameter int unsigned DW        = 16,
  parameter int unsigned LOG2_TAPS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CH*DW-1:0] din,
  input  logic [CH-1:0]    din_en,
  output logic [CH*DW-1:0] ori_dout,
  output logic [CH-1:0]    ori_en,
  output logic [CH*DW-1:0] dout,
  output logic [CH-1:0]    dout_en,
  output logic [CH-1:0]    dout_sign,
  output logic [CH-1:0]    overrun
);

  localparam int unsigned TAPS = 1 << LOG2_TAPS;
  localparam int unsigned SW   = DW + LOG2_TAPS;
  localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};

  logic [CH-1:0]               pend;
  logic [DW-1:0]               pend_data [CH];
  logic [CW-1:0]               rr_ptr;
  logic                        gnt_vld_c;
  logic [CW-1:0]               gnt_ch_c;

  logic [LOG2_TAPS-1:0]        wr_ptr [CH];
  logic signed [DW-1:0]        hist [CH][TAPS];
  logic                        s1_vld;
  logic [CW-1:0]               s1_ch;
  logic signed [DW-1:0]        s1_x;
  logic signed [DW-1:0]        s1_old;

  logic signed [SW-1:0]        sum_r [CH];
  logic signed [SW-1:0]        sum_nxt_c;
  logic                        s2_vld;
  logic [CW-1:0]               s2_ch;
  logic signed [SW-1:0]        s2_sum;

  logic signed [DW-1:0]        y_c;
  logic [DW-1:0]               dout_val_c;

  // Round-robin arbiter: first pending channel at or after rr_ptr
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_ch_c  = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (!gnt_vld_c && pend[CW'((32'(rr_ptr) + i) % CH)]) begin
        gnt_vld_c = 1'b1;
        gnt_ch_c  = CW'((32'(rr_ptr) + i) % CH);
      end
    end
  end

  // Capture, passthrough, overrun tracking and arbiter pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      overrun  <= '0;
      ori_en   <= '0;
      ori_dout <= '0;
      rr_ptr   <= '0;
      for (int unsigned c = 0; c < CH; c++) pend_data[c] <= '0;
    end else if (clr) begin
      pend     <= '0;
      overrun  <= '0;
      ori_en   <= '0;
      ori_dout <= '0;
      rr_ptr   <= '0;
      for (int unsigned c = 0; c < CH; c++) pend_data[c] <= '0;
    end else begin
      ori_en <= din_en;
      if (gnt_vld_c) rr_ptr <= (gnt_ch_c == CW'(CH - 1)) ? '0 : gnt_ch_c + CW'(1);
      for (int unsigned c = 0; c < CH; c++) begin
        if (din_en[c]) begin
          ori_dout[c*DW +: DW] <= din[c*DW +: DW];
          pend[c]              <= 1'b1;
          pend_data[c]         <= din[c*DW +: DW];
          // A sample still waiting and not leaving this cycle is lost
          if (pend[c] && !(gnt_vld_c && gnt_ch_c == CW'(c))) overrun[c] <= 1'b1;
        end else if (gnt_vld_c && gnt_ch_c == CW'(c)) begin
          pend[c] <= 1'b0;
        end
      end
    end
  end

  // S1: fetch oldest tap and replace it with the granted sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_ch  <= '0;
      s1_x   <= '0;
      s1_old <= '0;
      for (int unsigned c = 0; c < CH; c++) begin
        wr_ptr[c] <= '0;
        for (int unsigned t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end
    end else if (clr) begin
      s1_vld <= 1'b0;
      s1_ch  <= '0;
      s1_x   <= '0;
      s1_old <= '0;
      for (int unsigned c = 0; c < CH; c++) begin
        wr_ptr[c] <= '0;
        for (int unsigned t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end
    end else begin
      s1_vld <= gnt_vld_c;
      if (gnt_vld_c) begin
        s1_ch                               <= gnt_ch_c;
        s1_x                                <= $signed(pend_data[gnt_ch_c]);
        s1_old                              <= hist[gnt_ch_c][wr_ptr[gnt_ch_c]];
        hist[gnt_ch_c][wr_ptr[gnt_ch_c]]    <= $signed(pend_data[gnt_ch_c]);
        wr_ptr[gnt_ch_c]                    <= wr_ptr[gnt_ch_c] + LOG2_TAPS'(1);
      end
    end
  end

  // Running sum is read and written in the same stage, so same-channel grants on consecutive cycles stay coherent
  assign sum_nxt_c = sum_r[s1_ch] + SW'(s1_x) - SW'(s1_old);

  // S2: running-sum update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld <= 1'b0;
      s2_ch  <= '0;
      s2_sum <= '0;
      for (int unsigned c = 0; c < CH; c++) sum_r[c] <= '0;
    end else if (clr) begin
      s2_vld <= 1'b0;
      s2_ch  <= '0;
      s2_sum <= '0;
      for (int unsigned c = 0; c < CH; c++) sum_r[c] <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        sum_r[s1_ch] <= sum_nxt_c;
        s2_ch        <= s1_ch;
        s2_sum       <= sum_nxt_c;
      end
    end
  end

  // Average with floor rounding, then output formatting
  always_comb begin
    y_c = DW'(s2_sum >>> LOG2_TAPS);
`ifdef FILTER_SIGNMAG_EN
    dout_val_c = y_c[DW-1] ? DW'(-y_c) : y_c;
    if (y_c == S_MIN) dout_val_c = S_MAX;
`else
    dout_val_c = y_c;
`endif
  end

  // S3: per-channel output registers, untouched channels hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout      <= '0;
      dout_en   <= '0;
      dout_sign <= '0;
    end else if (clr) begin
      dout      <= '0;
      dout_en   <= '0;
      dout_sign <= '0;
    end else begin
      for (int unsigned c = 0; c < CH; c++) begin
        dout_en[c] <= s2_vld && (s2_ch == CW'(c));
        if (s2_vld && (s2_ch == CW'(c))) begin
          dout[c*DW +: DW] <= dout_val_c;
          dout_sign[c]     <= y_c[DW-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_boxcar_mc.sv
// Self-checking bench for filter_boxcar_mc (CH=4, DW=16, LOG2_TAPS=2): directed scenarios plus randomized traffic.
module tb_filter_boxcar_mc;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int L  = 2;
  localparam int T  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [CH*DW-1:0] din;
  logic [CH-1:0]    din_en;
  logic [CH*DW-1:0] ori_dout;
  logic [CH-1:0]    ori_en;
  logic [CH*DW-1:0] dout;
  logic [CH-1:0]    dout_en;
  logic [CH-1:0]    dout_sign;
  logic [CH-1:0]    overrun;

  int total = 0;
  int bad   = 0;

  filter_boxcar_mc #(.CH(CH), .DW(DW), .LOG2_TAPS(L)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_en(din_en),
    .ori_dout(ori_dout), .ori_en(ori_en), .dout(dout), .dout_en(dout_en),
    .dout_sign(dout_sign), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] exp_dout(input int y);
`ifdef FILTER_SIGNMAG_EN
    int a;
    a = (y < 0) ? -y : y;
    if (a > 32767) a = 32767;
    return DW'(a);
`else
    return DW'(y);
`endif
  endfunction

  function automatic int floor_avg(input int s);
    int q;
    q = s / T;
    if ((s % T) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [DW-1:0] sl(input logic [CH*DW-1:0] v, input int c);
    return v[c*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int c, input int val);
    din[c*DW +: DW] = DW'(val);
    din_en[c]       = 1'b1;
  endtask

  task automatic do_clr();
    din_en = '0;
    clr    = 1'b1;
    tick();
    clr    = 1'b0;
  endtask

  // Returns ticks until dout_en[ch] rises, or -1 on timeout
  task automatic wait_en(input int ch, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (dout_en[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    total++;
    if ({dout, dout_en, ori_dout, ori_en, dout_sign, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", {dout, dout_en, ori_dout, ori_en, dout_sign, overrun});
    end
    #4 rst = 1'b1;
    tick();
    for (int c = 0; c < CH; c++) set_in(c, 20 * (c + 1));
    tick();
    din_en = '0;
    set_in(0, 7);
    tick();
    din_en = '0;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({dout, dout_en, ori_dout, ori_en, dout_sign, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_async: got %h want 0", {dout, dout_en, ori_dout, ori_en, dout_sign, overrun});
    end
    #2 rst = 1'b1;
    tick();
    total++;
    if (dout_en !== '0) begin
      bad++;
      $display("FAIL reset_no_stale: got %b want 0000", dout_en);
    end
    set_in(0, 40);
    tick();
    din_en = '0;
    wait_en(0, 10, n);
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL reset_first_latency: got %0d want 3", n);
    end
    total++;
    if (sl(dout, 0) !== exp_dout(10)) begin
      bad++;
      $display("FAIL reset_first_value: got %h want %h", sl(dout, 0), exp_dout(10));
    end
  endtask

  task automatic test_step();
    int n;
    do_clr();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 100);
      tick();
      din_en = '0;
      total++;
      if (ori_en !== 4'b0001 || sl(ori_dout, 0) !== 16'd100) begin
        bad++;
        $display("FAIL step_ori[%0d]: got en=%b d=%0d want en=0001 d=100", i, ori_en, sl(ori_dout, 0));
      end
      wait_en(0, 10, n);
      total++;
      if (n !== 3) begin
        bad++;
        $display("FAIL step_latency[%0d]: got %0d want 3", i, n);
      end
      total++;
      if (sl(dout, 0) !== exp_dout(25 * (i + 1))) begin
        bad++;
        $display("FAIL step_value[%0d]: got %h want %h", i, sl(dout, 0), exp_dout(25 * (i + 1)));
      end
      repeat (4) tick();
    end
  endtask

  task automatic test_contention();
    logic [CH-1:0] want;
    do_clr();
    for (int c = 0; c < CH; c++) set_in(c, 4 * (c + 1));
    tick();
    din_en = '0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      want = (k >= 3 && k <= 6) ? CH'(1 << (k - 3)) : '0;
      total++;
      if (dout_en !== want) begin
        bad++;
        $display("FAIL contention_en[+%0d]: got %b want %b", k, dout_en, want);
      end
      if (k >= 3 && k <= 6) begin
        total++;
        if (sl(dout, k - 3) !== exp_dout(k - 2)) begin
          bad++;
          $display("FAIL contention_value[ch%0d]: got %h want %h", k - 3, sl(dout, k - 3), exp_dout(k - 2));
        end
      end
    end
    total++;
    if (overrun !== '0) begin
      bad++;
      $display("FAIL contention_overrun: got %b want 0000", overrun);
    end
  endtask

  task automatic test_negative();
    int n;
    int base [2];
    base[0] = -8;
    base[1] = -32768;
    for (int b = 0; b < 2; b++) begin
      do_clr();
      for (int i = 0; i < 4; i++) begin
        set_in(1, base[b]);
        tick();
        din_en = '0;
        wait_en(1, 10, n);
        total++;
        if (n !== 3 || sl(dout, 1) !== exp_dout(base[b] / 4 * (i + 1))) begin
          bad++;
          $display("FAIL negative_value[%0d,%0d]: got n=%0d d=%h want n=3 d=%h", b, i, n, sl(dout, 1),
                   exp_dout(base[b] / 4 * (i + 1)));
        end
        total++;
        if (dout_sign[1] !== 1'b1) begin
          bad++;
          $display("FAIL negative_sign[%0d,%0d]: got %b want 1", b, i, dout_sign[1]);
        end
        repeat (3) tick();
      end
    end
  endtask

  task automatic test_overrun();
    logic [CH-1:0] want;
    do_clr();
    for (int c = 0; c < CH; c++) set_in(c, 4 * (c + 1));
    tick();
    din_en = '0;
    set_in(3, 50);
    tick();
    din_en = '0;
    total++;
    if (overrun !== 4'b1000) begin
      bad++;
      $display("FAIL overrun_flag: got %b want 1000", overrun);
    end
    for (int k = 2; k <= 7; k++) begin
      tick();
      want = (k >= 3 && k <= 6) ? CH'(1 << (k - 3)) : '0;
      total++;
      if (dout_en !== want) begin
        bad++;
        $display("FAIL overrun_en[+%0d]: got %b want %b", k, dout_en, want);
      end
    end
    total++;
    if (sl(dout, 3) !== exp_dout(12) || overrun !== 4'b1000) begin
      bad++;
      $display("FAIL overrun_ch3: got d=%h ovr=%b want d=%h ovr=1000", sl(dout, 3), overrun, exp_dout(12));
    end
    do_clr();
    total++;
    if (overrun !== '0 || dout !== '0) begin
      bad++;
      $display("FAIL overrun_clr: got ovr=%b d=%h want 0", overrun, dout);
    end
  endtask

  task automatic test_back_to_back();
    int exp_v [4];
    exp_v[0] = 1; exp_v[1] = 3; exp_v[2] = 6; exp_v[3] = 10;
    do_clr();
    for (int k = 0; k <= 8; k++) begin
      din_en = '0;
      if (k < 4) set_in(2, 4 * (k + 1));
      tick();
      total++;
      if (dout_en !== ((k >= 3 && k <= 6) ? 4'b0100 : 4'b0000)) begin
        bad++;
        $display("FAIL b2b_en[+%0d]: got %b", k, dout_en);
      end
      if (k >= 3 && k <= 6) begin
        total++;
        if (sl(dout, 2) !== exp_dout(exp_v[k - 3])) begin
          bad++;
          $display("FAIL b2b_value[+%0d]: got %h want %h", k, sl(dout, 2), exp_dout(exp_v[k - 3]));
        end
      end
    end
    total++;
    if (overrun !== '0) begin
      bad++;
      $display("FAIL b2b_overrun: got %b want 0000", overrun);
    end
  endtask

  // Random traffic, each channel spaced >= CH cycles so no sample should be lost
  task automatic test_random();
    int hq [CH][$];
    int expv [CH][$];
    int expt [CH][$];
    int last [CH];
    int sent [CH];
    int s, y, t0;
    logic [CH-1:0] en;
    logic [DW-1:0] v;
    do_clr();
    for (int c = 0; c < CH; c++) last[c] = -100;
    for (int cyc = 0; cyc < 412; cyc++) begin
      en = '0;
      for (int c = 0; c < CH; c++) begin
        sent[c] = 0;
        if (cyc < 400 && cyc - last[c] >= CH && $urandom_range(0, 1) == 1) begin
          v = DW'($urandom);
          en[c] = 1'b1;
          din[c*DW +: DW] = v;
          sent[c] = int'($signed(v));
          last[c] = cyc;
          hq[c].push_back(sent[c]);
          if (hq[c].size() > T) void'(hq[c].pop_front());
          s = 0;
          foreach (hq[c][i]) s += hq[c][i];
          expv[c].push_back(floor_avg(s));
          expt[c].push_back(cyc);
        end
      end
      din_en = en;
      tick();
      din_en = '0;
      total++;
      if (ori_en !== en) begin
        bad++;
        $display("FAIL rand_ori_en[%0d]: got %b want %b", cyc, ori_en, en);
      end
      for (int c = 0; c < CH; c++) begin
        if (en[c]) begin
          total++;
          if (sl(ori_dout, c) !== DW'(sent[c])) begin
            bad++;
            $display("FAIL rand_ori[%0d,ch%0d]: got %h want %h", cyc, c, sl(ori_dout, c), DW'(sent[c]));
          end
        end
        if (dout_en[c]) begin
          total++;
          if (expv[c].size() == 0) begin
            bad++;
            $display("FAIL rand_spurious[%0d,ch%0d]: got dout_en want none", cyc, c);
          end else begin
            y  = expv[c].pop_front();
            t0 = expt[c].pop_front();
            if (sl(dout, c) !== exp_dout(y) || dout_sign[c] !== (y < 0) ||
                cyc - t0 < 3 || cyc - t0 > CH + 2) begin
              bad++;
              $display("FAIL rand_out[%0d,ch%0d]: got d=%h s=%b lat=%0d want d=%h s=%b lat 3..%0d",
                       cyc, c, sl(dout, c), dout_sign[c], cyc - t0, exp_dout(y), (y < 0), CH + 2);
            end
          end
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      total++;
      if (expv[c].size() != 0) begin
        bad++;
        $display("FAIL rand_missing[ch%0d]: got %0d outstanding want 0", c, expv[c].size());
      end
    end
    total++;
    if (overrun !== '0) begin
      bad++;
      $display("FAIL rand_overrun: got %b want 0000", overrun);
    end
  endtask

  initial begin
    rst    = 1'b0;
    clr    = 1'b0;
    din    = '0;
    din_en = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_step();
    test_contention();
    test_negative();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
